// File: rtl/pool_pkg.sv
// Shared types and helpers for the 2x2 stride-2 pooling stream.
package pool_pkg;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    localparam int MAX_LANE_DW = 32;

    // Unsigned maximum of one channel sample, zero-extended to the widest lane.
    function automatic logic [MAX_LANE_DW-1:0] lane_max(
        input logic [MAX_LANE_DW-1:0] a,
        input logic [MAX_LANE_DW-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_lane.sv
// Single-channel 2x2 combine: the pair value kept in the line buffer and the final window value.
// STREAM_POOL_AVG_EN adds the rounding-average datapath selected by mode.
module pool_lane
    import pool_pkg::*;
#(
    parameter int DW  = 1,
    parameter int LBW = DW
) (
`ifdef STREAM_POOL_AVG_EN
    input  pool_mode_e     mode,
`endif
    input  logic [DW-1:0]  held,
    input  logic [DW-1:0]  cur,
    input  logic [LBW-1:0] line_entry,
    output logic [LBW-1:0] pair,
    output logic [DW-1:0]  win
);

    logic [DW-1:0] pair_max;
`ifdef STREAM_POOL_AVG_EN
    localparam int SW = DW + 2;
    logic [SW-1:0] quad_sum;
`endif

    // Max is the default; average mode widens the pair to a sum and rounds the window to nearest.
    always_comb begin
        pair_max = DW'(lane_max(MAX_LANE_DW'(held), MAX_LANE_DW'(cur)));
        pair     = LBW'(pair_max);
        win      = DW'(lane_max(MAX_LANE_DW'(line_entry[DW-1:0]), MAX_LANE_DW'(pair_max)));
`ifdef STREAM_POOL_AVG_EN
        quad_sum = '0;
        if (mode == POOL_AVG) begin
            pair     = LBW'({1'b0, held} + {1'b0, cur});
            quad_sum = SW'(line_entry) + SW'({1'b0, held} + {1'b0, cur}) + SW'(2);
            win      = quad_sum[SW-1:2];
        end
`endif
    end

endmodule

// File: rtl/pool_stream.sv
// Streaming 2x2 stride-2 pooling over a raster pixel stream, all channels in parallel.
// Define STREAM_POOL_AVG_EN to add the mode_avg port and a per-frame rounding-average mode.
module pool_stream
    import pool_pkg::*;
#(
    parameter int CH    = 20,
    parameter int DW    = 1,
    parameter int IMG_W = 24,
    parameter int IMG_H = 24
) (
    input  logic             clk,
    input  logic             rst,
`ifdef STREAM_POOL_AVG_EN
    input  logic             mode_avg,
`endif
    input  logic             in_valid,
    input  logic [CH*DW-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [CH*DW-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready
);

`ifdef STREAM_POOL_AVG_EN
    localparam int LBW = DW + 1;
`else
    localparam int LBW = DW;
`endif
    localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int HALF_W = IMG_W / 2;
    localparam int AW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    if ((IMG_W % 2) != 0) begin : g_bad_width
        $error("pool_stream: IMG_W must be even");
    end
    if ((IMG_H % 2) != 0) begin : g_bad_height
        $error("pool_stream: IMG_H must be even");
    end

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [CH*DW-1:0]  held_q;
    logic [CH*DW-1:0]  win_all;
    logic [CH*LBW-1:0] pair_all;
    logic [CH*LBW-1:0] line_rd;
    logic [CH*LBW-1:0] line_buf [HALF_W];
    logic [AW-1:0]     lb_idx;
    logic              accept;
    logic              col_end;
    logic              row_end;
`ifdef STREAM_POOL_AVG_EN
    pool_mode_e        mode_q;
`endif

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign lb_idx   = AW'(col >> 1);
    assign col_end  = (col == CW'(IMG_W - 1));
    assign row_end  = (row == RW'(IMG_H - 1));
    assign line_rd  = line_buf[lb_idx];

    // Even columns park the pixel; odd columns on odd rows finish a window into the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            held_q    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (accept) begin
                if (!col[0]) begin
                    held_q <= in_data;
                end else if (row[0]) begin
                    out_data  <= win_all;
                    out_valid <= 1'b1;
                    out_last  <= col_end && row_end;
                end
                if (col_end) begin
                    col <= '0;
                    row <= row_end ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    // Line buffer is never cleared: each entry is rewritten on the even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (accept && col[0] && !row[0]) begin
            line_buf[lb_idx] <= pair_all;
        end
    end

`ifdef STREAM_POOL_AVG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= POOL_MAX;
        end else if (accept && (col == '0) && (row == '0)) begin
            mode_q <= mode_avg ? POOL_AVG : POOL_MAX;
        end
    end
`endif

    for (genvar c = 0; c < CH; c++) begin : g_lane
        pool_lane #(
            .DW  (DW),
            .LBW (LBW)
        ) u_lane (
`ifdef STREAM_POOL_AVG_EN
            .mode       (mode_q),
`endif
            .held       (held_q[c*DW +: DW]),
            .cur        (in_data[c*DW +: DW]),
            .line_entry (line_rd[c*LBW +: LBW]),
            .pair       (pair_all[c*LBW +: LBW]),
            .win        (win_all[c*DW +: DW])
        );
    end

endmodule

// File: tb/tb_pool_stream.sv
// Bench for pool_stream: a small 2-channel 4x4 instance and a default-parameter instance,
// both checked against a whole-frame 2x2 pooling model.
module tb_pool_stream;

    localparam int S_CH = 2,  S_DW = 4, S_W = 4,  S_H = 4,  S_BITS = S_CH * S_DW;
    localparam int D_CH = 20, D_DW = 1, D_W = 24, D_H = 24, D_BITS = D_CH * D_DW;
`ifdef STREAM_POOL_AVG_EN
    localparam bit AVG_BUILT = 1'b1;
`else
    localparam bit AVG_BUILT = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        bit          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic              s_in_valid, s_in_ready, s_out_valid, s_out_last, s_out_ready;
    logic [S_BITS-1:0] s_in_data, s_out_data;
    logic              d_in_valid, d_in_ready, d_out_valid, d_out_last, d_out_ready;
    logic [D_BITS-1:0] d_in_data, d_out_data;
`ifdef STREAM_POOL_AVG_EN
    logic              s_mode_avg, d_mode_avg;
`endif

    int          vectors = 0;
    int          miscompares = 0;
    int          s_ready_mode = 1;
    int          d_ready_mode = 1;
    exp_t        s_q[$], d_q[$];
    exp_t        s_e, d_e;
    logic [31:0] s_log[$], d_log[$];
    bit          s_last_log[$];
    int          d_out_cnt, d_last_beat;
    logic [31:0] s_frame [S_H][S_W];
    logic [31:0] d_frame [D_H][D_W];
    int          s_r, s_c, d_r, d_c;
    bit          s_avg;
    logic [31:0] s_pix [S_W*S_H];

    always #5 clk = ~clk;

    pool_stream #(.CH(S_CH), .DW(S_DW), .IMG_W(S_W), .IMG_H(S_H)) dut_s (
        .clk       (clk),
        .rst       (rst),
`ifdef STREAM_POOL_AVG_EN
        .mode_avg  (s_mode_avg),
`endif
        .in_valid  (s_in_valid),
        .in_data   (s_in_data),
        .in_ready  (s_in_ready),
        .out_valid (s_out_valid),
        .out_data  (s_out_data),
        .out_last  (s_out_last),
        .out_ready (s_out_ready)
    );

    pool_stream dut_d (
        .clk       (clk),
        .rst       (rst),
`ifdef STREAM_POOL_AVG_EN
        .mode_avg  (d_mode_avg),
`endif
        .in_valid  (d_in_valid),
        .in_data   (d_in_data),
        .in_ready  (d_in_ready),
        .out_valid (d_out_valid),
        .out_data  (d_out_data),
        .out_last  (d_out_last),
        .out_ready (d_out_ready)
    );

    // 0 = hold low, 1 = hold high, 2 = random backpressure
    always @(posedge clk) begin
        #2;
        s_out_ready = (s_ready_mode == 2) ? ($urandom_range(0, 3) != 0) : (s_ready_mode == 1);
        d_out_ready = (d_ready_mode == 2) ? ($urandom_range(0, 3) != 0) : (d_ready_mode == 1);
    end

    // Per channel: unsigned max of the four samples, or (sum+2)>>2 in average mode.
    function automatic logic [31:0] pool_pix(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c, input logic [31:0] d,
                                             input int ch_n, input int dw, input bit avg);
        logic [31:0] res;
        int          mask;
        int          s[4];
        int          v;
        res  = '0;
        mask = (1 << dw) - 1;
        for (int ch = 0; ch < ch_n; ch++) begin
            s[0] = int'((a >> (ch * dw)) & 32'(mask));
            s[1] = int'((b >> (ch * dw)) & 32'(mask));
            s[2] = int'((c >> (ch * dw)) & 32'(mask));
            s[3] = int'((d >> (ch * dw)) & 32'(mask));
            if (avg) begin
                v = ((s[0] + s[1] + s[2] + s[3] + 2) >> 2) & mask;
            end else begin
                v = s[0];
                for (int k = 1; k < 4; k++) if (s[k] > v) v = s[k];
            end
            res = res | (32'(v) << (ch * dw));
        end
        return res;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_s(input logic [31:0] px, input bit mode);
        exp_t e;
        if (s_r == 0 && s_c == 0) s_avg = mode;
        s_frame[s_r][s_c] = px;
        if ((s_r % 2) == 1 && (s_c % 2) == 1) begin
            e.data = pool_pix(s_frame[s_r-1][s_c-1], s_frame[s_r-1][s_c], s_frame[s_r][s_c-1], px,
                              S_CH, S_DW, s_avg);
            e.last = (s_r == S_H - 1) && (s_c == S_W - 1);
            s_q.push_back(e);
        end
        s_c++;
        if (s_c == S_W) begin
            s_c = 0;
            s_r = (s_r == S_H - 1) ? 0 : s_r + 1;
        end
    endtask

    task automatic model_d(input logic [31:0] px);
        exp_t e;
        d_frame[d_r][d_c] = px;
        if ((d_r % 2) == 1 && (d_c % 2) == 1) begin
            e.data = pool_pix(d_frame[d_r-1][d_c-1], d_frame[d_r-1][d_c], d_frame[d_r][d_c-1], px,
                              D_CH, D_DW, 1'b0);
            e.last = (d_r == D_H - 1) && (d_c == D_W - 1);
            d_q.push_back(e);
        end
        d_c++;
        if (d_c == D_W) begin
            d_c = 0;
            d_r = (d_r == D_H - 1) ? 0 : d_r + 1;
        end
    endtask

    // Offer one pixel and wait (bounded) for the beat that accepts it; sel 0 = small, 1 = default DUT.
    task automatic apply_stimulus(input bit sel, input logic [31:0] px, input bit mode);
        int n;
        bit rdy;
        bit eff;
        n   = 0;
        eff = mode && AVG_BUILT;
        if (sel == 1'b0) begin
            s_in_valid = 1'b1;
            s_in_data  = S_BITS'(px);
`ifdef STREAM_POOL_AVG_EN
            s_mode_avg = mode;
`endif
        end else begin
            d_in_valid = 1'b1;
            d_in_data  = D_BITS'(px);
        end
        @(negedge clk);
        rdy = sel ? d_in_ready : s_in_ready;
        while (!rdy && n < 200) begin
            n++;
            @(negedge clk);
            rdy = sel ? d_in_ready : s_in_ready;
        end
        if (!rdy) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s_accept_timeout: in_ready stayed 0, expected 1", sel ? "d" : "s");
        end
        @(posedge clk);
        if (rdy) begin
            if (sel == 1'b0) model_s(px, eff);
            else model_d(px);
        end
        #1;
        s_in_valid = 1'b0;
        d_in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        s_in_valid = 1'b0;
        d_in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_output("rst_s_out_valid", 32'(s_out_valid), 32'd0);
        check_output("rst_s_out_last",  32'(s_out_last),  32'd0);
        check_output("rst_s_out_data",  32'(s_out_data),  32'd0);
        check_output("rst_d_out_valid", 32'(d_out_valid), 32'd0);
        check_output("rst_d_out_data",  32'(d_out_data),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        s_q.delete(); d_q.delete(); s_log.delete(); d_log.delete(); s_last_log.delete();
        s_r = 0; s_c = 0; d_r = 0; d_c = 0;
        d_out_cnt = 0; d_last_beat = 0;
        @(negedge clk);
        check_output("post_rst_s_in_ready", 32'(s_in_ready), 32'd1);
        check_output("post_rst_d_in_ready", 32'(d_in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input bit sel);
        int n;
        n = 0;
        while (((sel ? d_q.size() : s_q.size()) != 0) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if ((sel ? d_q.size() : s_q.size()) != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s_drain_timeout: %0d outputs pending, expected 0", sel ? "d" : "s",
                     sel ? d_q.size() : s_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Every handshaked output is checked against the model queue.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (s_out_valid && s_out_ready) begin
                if (s_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL s_extra_output: got data %0h, expected no output", s_out_data);
                end else begin
                    s_e = s_q.pop_front();
                    check_output("s_data", 32'(s_out_data), s_e.data);
                    check_output("s_last", 32'(s_out_last), 32'(s_e.last));
                end
                s_log.push_back(32'(s_out_data));
                s_last_log.push_back(s_out_last);
            end
            if (d_out_valid && d_out_ready) begin
                d_out_cnt++;
                if (d_out_last) d_last_beat = d_out_cnt;
                if (d_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL d_extra_output: got data %0h, expected no output", d_out_data);
                end else begin
                    d_e = d_q.pop_front();
                    check_output("d_data", 32'(d_out_data), d_e.data);
                    check_output("d_last", 32'(d_out_last), 32'(d_e.last));
                end
                d_log.push_back(32'(d_out_data));
            end
        end
    end

    initial begin
        logic [7:0] ex_vals [4];
        logic [7:0] last_pat;
        bit         fmode;

        rst = 1'b1;
        s_in_valid = 1'b0; s_in_data = '0;
        d_in_valid = 1'b0; d_in_data = '0;
`ifdef STREAM_POOL_AVG_EN
        s_mode_avg = 1'b0;
        d_mode_avg = 1'b0;
`endif
        ex_vals = '{8'hF5, 8'hD7, 8'h7D, 8'h5F};
        for (int i = 0; i < S_W * S_H; i++) s_pix[i] = 32'({4'(15 - i), 4'(i)});

        $display("[TB] ramp frame, ch0 = index, ch1 = 15 - index");
        do_reset();
        s_ready_mode = 1;
        for (int i = 0; i < 16; i++) apply_stimulus(1'b0, s_pix[i], 1'b0);
        wait_drain(1'b0);
        check_output("ramp_count", 32'(s_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < s_log.size()) begin
                check_output($sformatf("ramp_beat%0d", i), s_log[i], 32'(ex_vals[i]));
                check_output($sformatf("ramp_last%0d", i), 32'(s_last_log[i]), 32'(i == 3));
            end
        end

        $display("[TB] backpressure hold");
        do_reset();
        s_ready_mode = 0;
        for (int i = 0; i < 6; i++) apply_stimulus(1'b0, s_pix[i], 1'b0);
        s_in_valid = 1'b1;
        s_in_data  = S_BITS'(s_pix[6]);
        repeat (5) begin
            @(negedge clk);
            check_output("stall_in_ready",  32'(s_in_ready),  32'd0);
            check_output("stall_out_valid", 32'(s_out_valid), 32'd1);
            check_output("stall_out_data",  32'(s_out_data),  32'hF5);
        end
        @(posedge clk);
        #1;
        s_ready_mode = 1;
        apply_stimulus(1'b0, s_pix[6], 1'b0);
        @(negedge clk);
        check_output("stall_consumed_once", 32'(s_out_valid), 32'd0);
        @(posedge clk);
        #1;
        s_ready_mode = 2;
        for (int i = 7; i < 16; i++) apply_stimulus(1'b0, s_pix[i], 1'b0);
        wait_drain(1'b0);
        check_output("stall_count", 32'(s_log.size()), 32'd4);

        $display("[TB] back-to-back frames");
        do_reset();
        s_ready_mode = 1;
        for (int i = 0; i < 32; i++) apply_stimulus(1'b0, 32'($urandom_range(0, 255)), 1'b0);
        wait_drain(1'b0);
        check_output("b2b_count", 32'(s_log.size()), 32'd8);
        last_pat = '0;
        for (int i = 0; i < 8; i++) if (i < s_last_log.size()) last_pat[i] = s_last_log[i];
        check_output("b2b_last_pattern", 32'(last_pat), 32'h88);

        $display("[TB] reset mid-frame");
        do_reset();
        for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 32'($urandom_range(0, 255)), 1'b0);
        wait_drain(1'b0);
        check_output("pre_reset_outputs", 32'(s_log.size()), 32'd1);
        do_reset();
        s_ready_mode = 2;
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b0, 32'($urandom_range(0, 255)), 1'b0);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        wait_drain(1'b0);
        check_output("post_reset_count", 32'(s_log.size()), 32'd4);

        $display("[TB] random small frames");
        for (int f = 0; f < 4; f++) begin
            fmode = 1'($urandom_range(0, 1));
            for (int i = 0; i < 16; i++) begin
                apply_stimulus(1'b0, 32'($urandom_range(0, 255)),
                               (i == 0) ? fmode : 1'($urandom_range(0, 1)));
                repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            end
        end
        wait_drain(1'b0);

        $display("[TB] default-parameter single-pixel window");
        do_reset();
        d_ready_mode = 1;
        for (int i = 0; i < D_W * D_H; i++) apply_stimulus(1'b1, (i == D_W + 1) ? 32'h20 : 32'h0, 1'b0);
        wait_drain(1'b1);
        if (d_log.size() > 1) begin
            check_output("d_pin_first", d_log[0], 32'h20);
            check_output("d_pin_second", d_log[1], 32'h0);
        end
        check_output("d_pin_count", 32'(d_out_cnt), 32'd144);

        $display("[TB] default-parameter random binary frames");
        do_reset();
        d_ready_mode = 2;
        for (int i = 0; i < D_W * D_H; i++) begin
            apply_stimulus(1'b1, 32'($urandom) & 32'hFFFFF, 1'b0);
            if ($urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
        end
        wait_drain(1'b1);
        check_output("d_frame_count", 32'(d_out_cnt), 32'd144);
        check_output("d_last_beat", 32'(d_last_beat), 32'd144);
        for (int i = 0; i < D_W * D_H; i++) apply_stimulus(1'b1, 32'($urandom) & 32'hFFFFF, 1'b0);
        wait_drain(1'b1);
        check_output("d_two_frame_count", 32'(d_out_cnt), 32'd288);
        check_output("d_two_frame_last", 32'(d_last_beat), 32'd288);

`ifdef STREAM_POOL_AVG_EN
        $display("[TB] average mode windows");
        do_reset();
        s_ready_mode = 1;
        s_pix = '{32'h01, 32'h02, 32'h00, 32'h00,
                  32'h03, 32'h04, 32'h00, 32'h01,
                  32'h0F, 32'h0F, 32'h35, 32'h77,
                  32'h0F, 32'h0F, 32'h2A, 32'hC9};
        for (int i = 0; i < 16; i++)
            apply_stimulus(1'b0, s_pix[i], (i == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
        wait_drain(1'b0);
        if (s_log.size() > 2) begin
            check_output("avg_1234",  s_log[0] & 32'hF, 32'd3);
            check_output("avg_0001",  s_log[1] & 32'hF, 32'd0);
            check_output("avg_15x4",  s_log[2] & 32'hF, 32'd15);
        end
        check_output("avg_count", 32'(s_log.size()), 32'd4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pool_stream.md
POOL_STREAM -- requirements
Module: pool_stream

Interface
REQ-001 Parameter CH, default 20: channel count, all channels processed in parallel.
REQ-002 Parameter DW, default 1: unsigned bits per channel sample; DW=1 is the binary feature-map case.
REQ-003 Parameter IMG_W, default 24: input columns; must be even, elaboration error otherwise.
REQ-004 Parameter IMG_H, default 24: input rows; must be even, elaboration error otherwise.
REQ-005 clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  input pixel present.
REQ-008 in_data  in  CH*DW  one pixel, all channels; channel c occupies bits [c*DW +: DW].
REQ-009 in_ready  out  1  block accepts in_data this cycle.
REQ-010 out_valid  out  1  pooled pixel present.
REQ-011 out_data  out  CH*DW  pooled pixel, same channel packing as in_data.
REQ-012 out_last  out  1  qualifies the final pooled pixel of a frame.
REQ-013 out_ready  in  1  downstream accepts out_data.

Function
REQ-014 Input is raster order, row-major, one pixel per accepted beat (in_valid && in_ready).
REQ-015 Output is the 2x2 stride-2 pool of each channel independently, (IMG_W/2)*(IMG_H/2) beats per frame, raster order.
REQ-016 Max mode: per channel, output is the unsigned maximum of the four window samples; for DW=1 this equals the OR.
REQ-017 Column counter 0..IMG_W-1 and row counter 0..IMG_H-1 advance on accepted beats only; both wrap to 0 after the pixel at (IMG_W-1, IMG_H-1), with no idle cycle between frames.
REQ-018 Even column: the pixel is held in a one-pixel register.
REQ-019 Even row, odd column: the pairwise maximum of the held pixel and the current pixel is written to line-buffer entry col/2 (IMG_W/2 entries of CH*DW bits).
REQ-020 Odd row, odd column: the maximum of line-buffer entry col/2, the held pixel and the current pixel is loaded into the output register, and out_valid is set.
REQ-021 Latency: out_valid is high in the cycle after the accepting beat of the window's last pixel.
REQ-022 out_valid stays high and out_data/out_last stay stable until out_valid && out_ready.
REQ-023 in_ready = !out_valid || out_ready; a new output may load in the same cycle the old one is consumed.
REQ-024 in_ready is also high whenever the accepted pixel will not produce an output (even row or even column), subject to REQ-023.
REQ-025 out_last is high with the output formed at (IMG_W-1, IMG_H-1), and low otherwise.

Reset
REQ-026 While rst is high: out_valid=0, out_last=0, out_data=0, counters=0, held register=0; in_ready=1 in the cycle after rst deasserts.
REQ-027 Reset mid-frame discards the partial frame; the next accepted pixel is (0,0). Line-buffer contents need not be cleared because every entry is rewritten before it is read.

Configuration
REQ-028 With STREAM_POOL_AVG_EN defined, an extra input port mode_avg (1 bit) exists. It is latched on the accepting beat of pixel (0,0) and held for the whole frame.
REQ-029 When the latched mode_avg=1, each channel output is (a+b+c+d+2)>>2, computed at DW+2 bits and truncated to DW. The line buffer then stores the DW+1-bit pair sums.
REQ-030 Without STREAM_POOL_AVG_EN, the mode_avg port and the average datapath are absent, the line buffer is DW bits per channel, and the block implements max mode only.

Structure
REQ-031 Shared package pool_pkg holds a pool_mode_e typedef (POOL_MAX, POOL_AVG) and a per-channel function for the unsigned max.
REQ-032 One sub-module, pool_lane, holds the single-channel combine logic (max or avg) and is instantiated CH times; counters, handshake and line buffer stay in pool_stream.

Verification
REQ-033 CH=2, DW=4, 4x4 frame, ch0 = row*4+col, ch1 = 15-(row*4+col), out_ready=1 -> ch0 outputs 5,7,13,15; ch1 outputs 15,13,7,5; out_last on the 4th beat only.
REQ-034 Default parameters (CH=20, DW=1, 24x24), random binary frame -> 144 outputs, each bit equal to the OR of its 2x2 window, out_last on beat 144.
REQ-035 Hold out_ready=0 for 5 cycles while an output is pending -> in_ready=0, out_data stable, no input accepted; on release, the output is consumed once.
REQ-036 Two back-to-back 4x4 frames with no gap -> 8 outputs, out_last on beats 4 and 8, second-frame values correct.
REQ-037 Assert rst after 6 accepted pixels, then send a full 4x4 frame -> exactly 4 outputs, all matching the new frame only.
REQ-038 With STREAM_POOL_AVG_EN, mode_avg=1, window {1,2,3,4} -> output 3; window {0,0,0,1} -> output 0; window {15,15,15,15} -> output 15.
